// File: rtl/fdd_track_flush.sv
// rtl/fdd_track_flush.sv - floppy track buffer flush/reload sequencer over SD sector bursts
// Optional write-back path (WR_XFER, dirty tracking) is built when FDD_WRITEBACK_EN is defined.
module fdd_track_flush #(
  parameter int SECS  = 13,
  parameter int TRK_W = 6
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [TRK_W-1:0] track,
  input  logic             buf_we,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic             img_present,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  output logic [3:0]       track_sec,
  output logic             cpu_wait,
  output logic             dirty
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_XFER = 2'd2;
`ifdef FDD_WRITEBACK_EN
  localparam logic [1:0] WR_XFER = 2'd1;
`endif
  localparam logic [3:0] LAST_SEC = 4'(SECS - 1);

  logic [1:0]       state;
  logic [TRK_W-1:0] cur_track;
  logic             reload;
  logic             abort;
  logic             ack_q;
  logic             ack_busy;
  logic [31:0]      lba_new;
  logic             ack_rise;
  logic             ack_fall;
  logic             req_on;
  logic             stop_req;
  logic             drop_now;
  logic             trk_change;

`ifdef FDD_WRITEBACK_EN
  logic        wr_q;
  logic        dirty_q;
  logic [31:0] lba_cur;
  assign lba_cur = 32'(SECS) * 32'(cur_track);
  assign sd_wr   = wr_q;
  assign dirty   = dirty_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{buf_we, img_readonly};
  assign sd_wr      = 1'b0;
  assign dirty      = 1'b0;
`endif

  assign lba_new    = 32'(SECS) * 32'(track);
  assign req_on     = sd_rd | sd_wr;
  assign ack_rise   = sd_ack & ~ack_q;
  // Only a fall that follows a rise seen within this burst counts; a stale ack after reset is ignored.
  assign ack_fall   = ~sd_ack & ack_q & ack_busy;
  assign stop_req   = abort | img_mounted;
  assign drop_now   = req_on & ((ack_rise & ((track_sec == LAST_SEC) | stop_req)) |
                                (ack_busy & stop_req));
  assign trk_change = (track != cur_track) | reload;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sd_rd     <= 1'b0;
      cpu_wait  <= 1'b0;
      track_sec <= 4'd0;
      sd_lba    <= 32'd0;
      cur_track <= '1;
      reload    <= 1'b0;
      abort     <= 1'b0;
      ack_q     <= 1'b0;
      ack_busy  <= 1'b0;
`ifdef FDD_WRITEBACK_EN
      wr_q      <= 1'b0;
      dirty_q   <= 1'b0;
`endif
    end else begin
      ack_q <= sd_ack;
      if (img_mounted) reload <= 1'b1;
      if (img_mounted && state != IDLE) abort <= 1'b1;
`ifdef FDD_WRITEBACK_EN
      if (img_mounted) dirty_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ack_busy <= 1'b0;
          abort    <= 1'b0;
`ifdef FDD_WRITEBACK_EN
          if (buf_we && !img_mounted) dirty_q <= 1'b1;
`endif
          if (trk_change) begin
            reload <= img_mounted;
`ifdef FDD_WRITEBACK_EN
            if (dirty_q && !img_readonly && img_present && !img_mounted) begin
              state     <= WR_XFER;
              wr_q      <= 1'b1;
              cpu_wait  <= 1'b1;
              track_sec <= 4'd0;
              sd_lba    <= lba_cur;
            end else
`endif
            if (img_present) begin
              cur_track <= track;
              state     <= RD_XFER;
              sd_rd     <= 1'b1;
              cpu_wait  <= 1'b1;
              track_sec <= 4'd0;
              sd_lba    <= lba_new;
`ifdef FDD_WRITEBACK_EN
              // Reloading overwrites the buffer, so unflushed (read-only) writes are discarded.
              dirty_q   <= 1'b0;
`endif
            end else begin
              cur_track <= track;
            end
          end
        end
        default: begin
          if (drop_now) begin
            sd_rd <= 1'b0;
`ifdef FDD_WRITEBACK_EN
            wr_q  <= 1'b0;
`endif
          end
          if (ack_rise && req_on) begin
            sd_lba   <= sd_lba + 32'd1;
            ack_busy <= 1'b1;
          end
          if (ack_fall) begin
            ack_busy  <= 1'b0;
            track_sec <= track_sec + 4'd1;
            if (!req_on || drop_now) begin
`ifdef FDD_WRITEBACK_EN
              if (state == WR_XFER && !stop_req) begin
                dirty_q   <= 1'b0;
                cur_track <= track;
                state     <= RD_XFER;
                sd_rd     <= 1'b1;
                track_sec <= 4'd0;
                sd_lba    <= lba_new;
              end else
`endif
              begin
                state    <= IDLE;
                cpu_wait <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdd_track_flush.sv
// tb/tb_fdd_track_flush.sv - scoreboard bench for fdd_track_flush with an SD ack responder
module tb_fdd_track_flush;

  localparam int SECS = 13;
`ifdef FDD_WRITEBACK_EN
  localparam logic WB = 1'b1;
`else
  localparam logic WB = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  track = 6'd0;
  logic        buf_we = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic        img_present = 1'b1;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack = 1'b0;
  logic [3:0]  track_sec;
  logic        cpu_wait;
  logic        dirty;

  logic [36:0] sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int served  = 0;

  always #5 clk_sys = ~clk_sys;

  fdd_track_flush #(.SECS(SECS), .TRK_W(6)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .track       (track),
    .buf_we      (buf_we),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_present (img_present),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .track_sec   (track_sec),
    .cpu_wait    (cpu_wait),
    .dirty       (dirty)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input logic wr, input int trk, input int first, input int last);
    for (int s = first; s <= last; s++)
      sb.push_back({wr, 4'(s), 32'(SECS * trk + s)});
  endtask

  task automatic wait_quiet(input string tag);
    int quiet = 0;
    int cyc = 0;
    while (quiet < 8 && cyc < 3000) begin
      @(negedge clk_sys);
      cyc++;
      if (!cpu_wait && !sd_rd && !sd_wr && !sd_ack) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_quiet"}, 64'(quiet >= 8), 64'd1);
  endtask

  task automatic wait_served(input string tag, input int n);
    int cyc = 0;
    while (served < n && cyc < 3000) begin
      @(negedge clk_sys);
      cyc++;
    end
    check_eq({tag, "_served"}, 64'(served >= n), 64'd1);
  endtask

  task automatic pulse_we();
    buf_we = 1'b1;
    @(negedge clk_sys);
    buf_we = 1'b0;
  endtask

  // SD card model: one ack pulse per requested sector; each sector is popped against the scoreboard.
  always begin
    logic [36:0] exp;
    @(negedge clk_sys);
    if (reset_n && (sd_rd || sd_wr)) begin
      @(negedge clk_sys);
      sd_ack = 1'b1;
      check_eq("one_req", 64'(sd_rd & sd_wr), 64'd0);
      check_eq("cpu_wait_burst", 64'(cpu_wait), 64'd1);
      if (sb.size() == 0) begin
        check_eq("extra_sector", 64'(sb.size()), 64'd1);
      end else begin
        exp = sb.pop_front();
        check_eq("sector", 64'({sd_wr, track_sec, sd_lba}), 64'(exp));
      end
      served++;
      repeat (3) @(negedge clk_sys);
      sd_ack = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_sd_rd", 64'(sd_rd), 64'd0);
    check_eq("rst_sd_wr", 64'(sd_wr), 64'd0);
    check_eq("rst_cpu_wait", 64'(cpu_wait), 64'd0);
    check_eq("rst_dirty", 64'(dirty), 64'd0);
    check_eq("rst_track_sec", 64'(track_sec), 64'd0);
    check_eq("rst_sd_lba", 64'(sd_lba), 64'd0);

    // first track after reset loads
    push_burst(1'b0, 0, 0, 12);
    reset_n = 1'b1;
    wait_quiet("boot");
    check_eq("boot_track_sec", 64'(track_sec), 64'd13);
    check_eq("boot_sb_empty", 64'(sb.size()), 64'd0);

    // dirty buffer flushed before the new track is read
    push_burst(1'b0, 3, 0, 12);
    track = 6'd3;
    wait_quiet("trk3");
    pulse_we();
    check_eq("wb_dirty_set", 64'(dirty), 64'(WB));
    if (WB) push_burst(1'b1, 3, 0, 12);
    push_burst(1'b0, 4, 0, 12);
    track = 6'd4;
    wait_quiet("wb");
    check_eq("wb_dirty_clr", 64'(dirty), 64'd0);
    check_eq("wb_track_sec", 64'(track_sec), 64'd13);
    check_eq("wb_sb_empty", 64'(sb.size()), 64'd0);

    // read-only image: writes are discarded
    push_burst(1'b0, 3, 0, 12);
    track = 6'd3;
    wait_quiet("ro_trk3");
    img_readonly = 1'b1;
    pulse_we();
    check_eq("ro_dirty_set", 64'(dirty), 64'(WB));
    push_burst(1'b0, 4, 0, 12);
    track = 6'd4;
    wait_quiet("ro");
    check_eq("ro_dirty_clr", 64'(dirty), 64'd0);
    check_eq("ro_sb_empty", 64'(sb.size()), 64'd0);
    img_readonly = 1'b0;

    // track changes during a burst are deferred, not aborting
    push_burst(1'b0, 5, 0, 12);
    track = 6'd5;
    wait_quiet("trk5");
    push_burst(1'b0, 6, 0, 12);
    push_burst(1'b0, 7, 0, 12);
    base = served;
    track = 6'd6;
    wait_served("chg6", base + 3);
    track = 6'd7;
    wait_quiet("chg7");
    check_eq("chg_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("chg_lba_end", 64'(sd_lba), 64'd104);

    // image mount during sector 4 stops the burst, then reloads
    if (WB) begin
      pulse_we();
      push_burst(1'b1, 7, 0, 4);
    end else begin
      push_burst(1'b0, 8, 0, 4);
    end
    push_burst(1'b0, 8, 0, 12);
    base = served;
    track = 6'd8;
    wait_served("mnt", base + 5);
    @(negedge clk_sys);
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    check_eq("mnt_dirty", 64'(dirty), 64'd0);
    wait_quiet("mnt");
    check_eq("mnt_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("mnt_track_sec", 64'(track_sec), 64'd13);

    // reset in the middle of sector 7, ack still in flight at release
    push_burst(1'b0, 9, 0, 7);
    base = served;
    track = 6'd9;
    wait_served("rst", base + 8);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_sd_rd", 64'(sd_rd), 64'd0);
    check_eq("rst_mid_cpu_wait", 64'(cpu_wait), 64'd0);
    check_eq("rst_mid_sb_empty", 64'(sb.size()), 64'd0);
    push_burst(1'b0, 9, 0, 12);
    @(negedge clk_sys);
    reset_n = 1'b1;
    wait_quiet("rst_reload");
    check_eq("rst_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("rst_track_sec_end", 64'(track_sec), 64'd13);
    check_eq("rst_lba_end", 64'(sd_lba), 64'd130);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
